// File: rtl/cpu_pkg.sv
// Shared types and width defaults for the 8-phase accumulator CPU.
// Imported by the fetch sequencer and the phase-decoding controller.
package cpu_pkg;

  localparam int AW_DEF = 5;
  localparam int DW_DEF = 8;

  typedef enum logic [2:0] {
    HLT = 3'd0,
    SKZ = 3'd1,
    ADD = 3'd2,
    AND = 3'd3,
    XOR = 3'd4,
    LDA = 3'd5,
    STO = 3'd6,
    JMP = 3'd7
  } opcode_e;

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_e;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } seq_state_e;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Controller/memory bundle of the fetch sequencer.
// FETCH_SEQ_SINGLE_STEP_EN adds the step_mode input.
interface fetch_sequencer_if #(
  parameter int AW    = 5,
  parameter int DW    = 8,
  parameter int CNT_W = 16
);
  logic [DW-1:0]    mem_data;
  logic             sel;
  logic             ld_ir;
  logic             inc_pc;
  logic             ld_pc;
  logic             halt;
  logic             resume;
`ifdef FETCH_SEQ_SINGLE_STEP_EN
  logic             step_mode;
`endif
  logic [2:0]       phase;
  logic [2:0]       opcode;
  logic [AW-1:0]    ir_addr;
  logic [AW-1:0]    pc;
  logic [AW-1:0]    addr;
  logic             halted;
  logic [CNT_W-1:0] instr_count;

  modport master (
    output mem_data, sel, ld_ir, inc_pc,
    output ld_pc, halt, resume,
`ifdef FETCH_SEQ_SINGLE_STEP_EN
    output step_mode,
`endif
    input  phase, opcode, ir_addr, pc,
    input  addr, halted, instr_count
  );

  modport slave (
    input  mem_data, sel, ld_ir, inc_pc,
    input  ld_pc, halt, resume,
`ifdef FETCH_SEQ_SINGLE_STEP_EN
    input  step_mode,
`endif
    output phase, opcode, ir_addr, pc,
    output addr, halted, instr_count
  );
endinterface

// File: rtl/fetch_sequencer_phase_counter.sv
// 3-bit phase wrap counter plus the RUN/HALTED state machine.
// wrap flags a RUN edge that takes phase from 7 back to 0.
module phase_counter
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       halt,
  input  logic       resume,
  input  logic       step,
  output logic [2:0] phase,
  output logic       halted,
  output logic       wrap
);

  seq_state_e state_q;
  seq_state_e state_d;
  logic [2:0] phase_q;
  logic       en;
  logic       clr;

  assign phase  = phase_q;
  assign halted = (state_q == HALTED);

  // Next state, counter enable and clear
  always_comb begin
    state_d = state_q;
    en      = 1'b0;
    clr     = 1'b0;
    wrap    = 1'b0;
    unique case (state_q)
      RUN: begin
        if (halt) begin
          state_d = HALTED;
        end else begin
          en   = 1'b1;
          wrap = (phase_q == 3'(STORE));
          if (wrap && step)
            state_d = HALTED;
        end
      end
      HALTED: begin
        if (resume) begin
          state_d = RUN;
          clr     = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_q <= RUN;
    else
      state_q <= state_d;
  end

  // Phase counter: sync clear beats enable, wraps 7 -> 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      phase_q <= 3'd0;
    else if (clr)
      phase_q <= 3'd0;
    else if (en)
      phase_q <= phase_q + 3'd1;
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch stage: phase, PC, IR, halt/resume and retired count.
// FETCH_SEQ_SINGLE_STEP_EN enables auto-halt after each instruction.
module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF,
  parameter int RESET_PC = 0,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  fetch_sequencer_if.slave    bus
);

  logic [AW-1:0]    pc_q;
  logic [DW-1:0]    ir_q;
  logic [CNT_W-1:0] cnt_q;
  logic [AW-1:0]    ir_addr;
  logic             halted;
  logic             wrap;
  logic             step;
  logic             run;

`ifdef FETCH_SEQ_SINGLE_STEP_EN
  assign step = bus.step_mode;
`else
  assign step = 1'b0;
`endif

  phase_counter u_phase (
    .clk    (clk),
    .rst    (rst),
    .halt   (bus.halt),
    .resume (bus.resume),
    .step   (step),
    .phase  (bus.phase),
    .halted (halted),
    .wrap   (wrap)
  );

  assign run     = ~halted;
  assign ir_addr = ir_q[AW-1:0];

  assign bus.halted      = halted;
  assign bus.pc          = pc_q;
  assign bus.ir_addr     = ir_addr;
  assign bus.opcode      = ir_q[DW-1:DW-3];
  assign bus.instr_count = cnt_q;
  assign bus.addr        = bus.sel ? pc_q : ir_addr;

  // PC: jump beats increment, frozen while halted
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      pc_q <= AW'(RESET_PC);
    else if (run && bus.ld_pc)
      pc_q <= ir_addr;
    else if (run && bus.inc_pc)
      pc_q <= pc_q + AW'(1);
  end

  // IR: load from memory on ld_ir while running
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ir_q <= '0;
    else if (run && bus.ld_ir)
      ir_q <= bus.mem_data;
  end

  // Retired count: one per completed 8-phase instruction
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt_q <= '0;
    else if (wrap)
      cnt_q <= cnt_q + CNT_W'(1);
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed tasks plus
// randomized strobes against a behavioural model.
module tb_fetch_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   passes = 0;

  fetch_sequencer_if bus ();

  fetch_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int         m_phase;
  int         m_pc;
  logic [7:0] m_ir;
  bit         m_halted;
  int         m_cnt;
  bit         m_step;

  task automatic clear_inputs();
    bus.mem_data = 8'h00;
    bus.sel      = 1'b1;
    bus.ld_ir    = 1'b0;
    bus.inc_pc   = 1'b0;
    bus.ld_pc    = 1'b0;
    bus.halt     = 1'b0;
    bus.resume   = 1'b0;
`ifdef FETCH_SEQ_SINGLE_STEP_EN
    bus.step_mode = 1'b0;
`endif
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_pc = 0;
    m_ir = 8'h00;
    m_halted = 0;
    m_cnt = 0;
  endtask

  task automatic model_step();
    int old_addr;
    old_addr = int'(m_ir[4:0]);
`ifdef FETCH_SEQ_SINGLE_STEP_EN
    m_step = bus.step_mode;
`else
    m_step = 0;
`endif
    if (m_halted) begin
      if (bus.resume) begin
        m_halted = 0;
        m_phase = 0;
      end
    end else begin
      if (bus.ld_ir) m_ir = bus.mem_data;
      if (bus.ld_pc) m_pc = old_addr;
      else if (bus.inc_pc) m_pc = (m_pc + 1) % 32;
      if (bus.halt) begin
        m_halted = 1;
      end else if (m_phase == 7) begin
        m_phase = 0;
        m_cnt = (m_cnt + 1) % 65536;
        if (m_step) m_halted = 1;
      end else begin
        m_phase = m_phase + 1;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus.phase !== 3'd0 || bus.pc !== 5'd0 || bus.halted !== 1'b0
        || bus.instr_count !== 16'd0 || bus.opcode !== 3'd0
        || bus.ir_addr !== 5'd0) begin
      $display("FAIL reset_state phase=%0d pc=%0d halted=%0b cnt=%0d op=%0d ira=%0d exp all 0",
               bus.phase, bus.pc, bus.halted, bus.instr_count, bus.opcode, bus.ir_addr);
    end else passes++;
    for (int i = 0; i < 8; i++) tick();
    bus.mem_data = 8'hE7;
    bus.ld_ir = 1'b1;
    tick();
    bus.ld_ir = 1'b0;
    bus.ld_pc = 1'b1;
    tick();
    bus.ld_pc = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (bus.phase !== 3'd5 || bus.pc !== 5'd7 || bus.instr_count !== 16'd1) begin
      $display("FAIL pre_reset phase=%0d pc=%0d cnt=%0d exp 5 7 1",
               bus.phase, bus.pc, bus.instr_count);
    end else passes++;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.phase !== 3'd0 || bus.pc !== 5'd0 || bus.halted !== 1'b0
        || bus.instr_count !== 16'd0 || bus.opcode !== 3'd0) begin
      $display("FAIL async_reset phase=%0d pc=%0d halted=%0b cnt=%0d op=%0d exp all 0",
               bus.phase, bus.pc, bus.halted, bus.instr_count, bus.opcode);
    end else passes++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_fetch();
    do_reset();
    tick();
    tick();
    bus.mem_data = 8'hA3;
    bus.ld_ir = 1'b1;
    tick();
    bus.ld_ir = 1'b0;
    checks++;
    if (bus.opcode !== 3'd5 || bus.ir_addr !== 5'd3 || bus.phase !== 3'd3) begin
      $display("FAIL fetch_ir op=%0d ira=%0d phase=%0d exp 5 3 3",
               bus.opcode, bus.ir_addr, bus.phase);
    end else passes++;
    tick();
    bus.inc_pc = 1'b1;
    tick();
    bus.inc_pc = 1'b0;
    checks++;
    if (bus.pc !== 5'd1) begin
      $display("FAIL fetch_inc pc=%0d exp 1", bus.pc);
    end else passes++;
    tick();
    tick();
    checks++;
    if (bus.phase !== 3'd7 || bus.instr_count !== 16'd0) begin
      $display("FAIL fetch_p7 phase=%0d cnt=%0d exp 7 0", bus.phase, bus.instr_count);
    end else passes++;
    tick();
    checks++;
    if (bus.phase !== 3'd0 || bus.instr_count !== 16'd1) begin
      $display("FAIL fetch_wrap phase=%0d cnt=%0d exp 0 1", bus.phase, bus.instr_count);
    end else passes++;
  endtask

  task automatic test_halt();
    do_reset();
    tick();
    tick();
    bus.mem_data = 8'h00;
    bus.ld_ir = 1'b1;
    tick();
    bus.ld_ir = 1'b0;
    tick();
    bus.halt = 1'b1;
    bus.inc_pc = 1'b1;
    tick();
    bus.halt = 1'b0;
    bus.inc_pc = 1'b0;
    checks++;
    if (bus.halted !== 1'b1 || bus.phase !== 3'd4 || bus.pc !== 5'd1) begin
      $display("FAIL halt_enter halted=%0b phase=%0d pc=%0d exp 1 4 1",
               bus.halted, bus.phase, bus.pc);
    end else passes++;
    for (int i = 0; i < 10; i++) begin
      bus.ld_ir = 1'b1;
      bus.mem_data = 8'($urandom);
      bus.inc_pc = 1'($urandom);
      bus.ld_pc = 1'($urandom);
      bus.halt = 1'($urandom);
      tick();
    end
    clear_inputs();
    checks++;
    if (bus.halted !== 1'b1 || bus.phase !== 3'd4 || bus.pc !== 5'd1
        || bus.opcode !== 3'd0 || bus.instr_count !== 16'd0) begin
      $display("FAIL halt_hold halted=%0b phase=%0d pc=%0d op=%0d cnt=%0d exp 1 4 1 0 0",
               bus.halted, bus.phase, bus.pc, bus.opcode, bus.instr_count);
    end else passes++;
    bus.resume = 1'b1;
    tick();
    bus.resume = 1'b0;
    checks++;
    if (bus.halted !== 1'b0 || bus.phase !== 3'd0 || bus.pc !== 5'd1) begin
      $display("FAIL halt_resume halted=%0b phase=%0d pc=%0d exp 0 0 1",
               bus.halted, bus.phase, bus.pc);
    end else passes++;
    bus.resume = 1'b1;
    tick();
    bus.halt = 1'b1;
    tick();
    clear_inputs();
    checks++;
    if (bus.halted !== 1'b1 || bus.phase !== 3'd1) begin
      $display("FAIL halt_wins halted=%0b phase=%0d exp 1 1", bus.halted, bus.phase);
    end else passes++;
  endtask

  task automatic test_jmp();
    do_reset();
    bus.mem_data = 8'hFD;
    bus.ld_ir = 1'b1;
    tick();
    bus.ld_ir = 1'b0;
    bus.ld_pc = 1'b1;
    bus.inc_pc = 1'b1;
    tick();
    bus.ld_pc = 1'b0;
    checks++;
    if (bus.pc !== 5'd29 || bus.opcode !== 3'd7) begin
      $display("FAIL jmp_pc pc=%0d op=%0d exp 29 7", bus.pc, bus.opcode);
    end else passes++;
    tick();
    tick();
    checks++;
    if (bus.pc !== 5'd31) begin
      $display("FAIL jmp_pc31 pc=%0d exp 31", bus.pc);
    end else passes++;
    tick();
    bus.inc_pc = 1'b0;
    checks++;
    if (bus.pc !== 5'd0) begin
      $display("FAIL pc_wrap pc=%0d exp 0", bus.pc);
    end else passes++;
  endtask

  task automatic test_addr_mux();
    do_reset();
    bus.mem_data = 8'h09;
    bus.ld_ir = 1'b1;
    tick();
    bus.ld_ir = 1'b0;
    bus.ld_pc = 1'b1;
    tick();
    bus.ld_pc = 1'b0;
    bus.mem_data = 8'h14;
    bus.ld_ir = 1'b1;
    tick();
    bus.ld_ir = 1'b0;
    bus.sel = 1'b1;
    #1;
    checks++;
    if (bus.addr !== 5'd9) begin
      $display("FAIL addr_sel1 addr=%0d exp 9", bus.addr);
    end else passes++;
    bus.sel = 1'b0;
    #1;
    checks++;
    if (bus.addr !== 5'd20) begin
      $display("FAIL addr_sel0 addr=%0d exp 20", bus.addr);
    end else passes++;
    bus.sel = 1'b1;
  endtask

  task automatic test_random();
    logic [4:0] e_addr;
    logic [2:0] e_phase;
    logic [4:0] e_pc;
    logic [15:0] e_cnt;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      bus.mem_data = 8'($urandom);
      bus.ld_ir = 1'($urandom);
      bus.inc_pc = 1'($urandom);
      bus.ld_pc = ($urandom_range(0, 3) == 0);
      bus.halt = ($urandom_range(0, 15) == 0);
      bus.resume = ($urandom_range(0, 3) == 0);
      bus.sel = 1'($urandom);
      #1;
      e_addr = bus.sel ? 5'(m_pc) : m_ir[4:0];
      checks++;
      if (bus.addr !== e_addr) begin
        $display("FAIL rnd_addr cyc=%0d addr=%0d exp %0d", i, bus.addr, e_addr);
      end else passes++;
      tick();
      e_phase = 3'(m_phase);
      e_pc = 5'(m_pc);
      e_cnt = 16'(m_cnt);
      checks++;
      if (bus.phase !== e_phase || bus.pc !== e_pc || bus.halted !== m_halted
          || bus.opcode !== m_ir[7:5] || bus.ir_addr !== m_ir[4:0]
          || bus.instr_count !== e_cnt) begin
        $display("FAIL rnd_state cyc=%0d got ph=%0d pc=%0d h=%0b ir=%0d/%0d cnt=%0d exp ph=%0d pc=%0d h=%0b ir=%0d/%0d cnt=%0d",
                 i, bus.phase, bus.pc, bus.halted, bus.opcode, bus.ir_addr,
                 bus.instr_count, e_phase, e_pc, m_halted, m_ir[7:5], m_ir[4:0], e_cnt);
      end else passes++;
    end
    clear_inputs();
  endtask

`ifdef FETCH_SEQ_SINGLE_STEP_EN
  task automatic test_single_step();
    do_reset();
    bus.step_mode = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    checks++;
    if (bus.halted !== 1'b0 || bus.phase !== 3'd7) begin
      $display("FAIL step_p7 halted=%0b phase=%0d exp 0 7", bus.halted, bus.phase);
    end else passes++;
    tick();
    checks++;
    if (bus.halted !== 1'b1 || bus.phase !== 3'd0 || bus.instr_count !== 16'd1) begin
      $display("FAIL step_halt halted=%0b phase=%0d cnt=%0d exp 1 0 1",
               bus.halted, bus.phase, bus.instr_count);
    end else passes++;
    for (int i = 0; i < 3; i++) tick();
    bus.resume = 1'b1;
    tick();
    bus.resume = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    checks++;
    if (bus.halted !== 1'b0 || bus.phase !== 3'd7 || bus.instr_count !== 16'd1) begin
      $display("FAIL step_run halted=%0b phase=%0d cnt=%0d exp 0 7 1",
               bus.halted, bus.phase, bus.instr_count);
    end else passes++;
    tick();
    checks++;
    if (bus.halted !== 1'b1 || bus.phase !== 3'd0 || bus.instr_count !== 16'd2) begin
      $display("FAIL step_again halted=%0b phase=%0d cnt=%0d exp 1 0 2",
               bus.halted, bus.phase, bus.instr_count);
    end else passes++;
    clear_inputs();
  endtask
`endif

  initial begin
    clear_inputs();
    model_reset();
    m_step = 0;
    #2;
    test_reset();
    test_fetch();
    test_halt();
    test_jmp();
    test_addr_mux();
    test_random();
`ifdef FETCH_SEQ_SINGLE_STEP_EN
    test_single_step();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Front-end timing and fetch stage of the 8-phase accumulator CPU. Owns the phase counter, program counter (PC) and instruction register (IR), and drives the phase/opcode pair consumed by the phase-decoding controller. Executes that controller's ld_ir/inc_pc/ld_pc/halt strobes and drives the memory address mux from its sel output. Also provides halt/resume control and a retired-instruction counter.

Parameters:
AW, 5, address width: PC width and IR operand-field width.
DW, 8, instruction/data width; IR = {opcode[DW-1:DW-3], operand[AW-1:0]}; requires DW = AW + 3.
RESET_PC, 0, PC value after reset.
CNT_W, 16, retired-instruction counter width.

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
mem_data  in  DW  instruction word from memory
sel  in  1  from controller: 1 = address from PC, 0 = from IR operand
ld_ir  in  1  from controller: load IR from mem_data
inc_pc  in  1  from controller: PC += 1
ld_pc  in  1  from controller: PC <= IR operand
halt  in  1  from controller: stop sequencing
resume  in  1  restart after halt, level sampled per clock
phase  out  3  current phase, 0..7
opcode  out  3  IR[DW-1:DW-3]
ir_addr  out  AW  IR[AW-1:0]
pc  out  AW  program counter
addr  out  AW  memory address = sel ? pc : ir_addr (combinational)
halted  out  1  1 while the sequencer is stopped
instr_count  out  CNT_W  retired instructions

Behaviour:
- One clock. Reset is asynchronous and active-high on rst.
- Reset values: phase=0, pc=RESET_PC, IR=0 (so opcode=0, ir_addr=0), halted=0, instr_count=0. Reset mid-instruction abandons that instruction; no strobe takes effect on the reset edge.
- Two states: RUN and HALTED.
  - RUN: phase advances +1 every clock; 7 wraps to 0.
  - HALTED: phase, pc, IR and instr_count hold. ld_ir, inc_pc, ld_pc and halt are ignored.
- RUN -> HALTED: halt=1 at a clock edge. On that edge:
  - halted <= 1.
  - phase holds its current value (4 for HLT) and does not advance.
  - inc_pc on the same edge is still honoured, so pc points past the HLT.
- HALTED -> RUN: resume=1 at an edge. On that edge halted <= 0 and phase <= 0. Normal fetch continues from pc.
- resume while in RUN has no effect. halt and resume together while in RUN: halt wins.
- PC update, only in RUN:
  - ld_pc has priority over inc_pc: pc <= ir_addr.
  - Otherwise inc_pc: pc <= pc+1, modulo 2^AW (31 -> 0 at AW=5).
  - ld_pc and inc_pc on the same edge: ld_pc wins, inc_pc is dropped.
- IR: ld_ir=1 in RUN gives IR <= mem_data on that edge. IR is otherwise held.
- instr_count increments modulo 2^CNT_W on every RUN edge where phase goes 7 -> 0. HLT never reaches phase 7, so it is not counted.
- Timing:
  - addr is combinational, zero latency from sel/pc/IR.
  - All other outputs are registered.
  - Strobes sampled at edge N take effect in the values visible after edge N.

Optional Feature:
Macro: FETCH_SEQ_SINGLE_STEP_EN.
- When defined: adds input step_mode (1 bit). In RUN with step_mode=1, the 7 -> 0 edge also sets halted <= 1; phase becomes 0 and holds. instr_count still increments on that edge. resume releases as normal, so one instruction executes per resume.
- When not defined: the port is absent and no auto-halt exists.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode enum HLT=0, SKZ, ADD, AND, XOR, LDA, STO, JMP=7.
  - phase enum INST_ADDR=0, INST_FETCH, INST_LOAD, IDLE, OP_ADDR, OP_FETCH, ALU_OP, STORE=7.
  - Width constants AW/DW defaults.
  - Both fetch_sequencer and the controller import it.
- One sub-module, phase_counter: 3-bit wrap counter with enable and sync clear, plus the RUN/HALTED state. PC/IR registers stay inline.

Test Plan:
1. Reset mid-run: assert rst at phase 5 with pc=7 -> phase=0, pc=0, halted=0, instr_count=0 immediately (asynchronously), with no clock edge needed.
2. Fetch: mem_data=8'hA3 with ld_ir at phase 2 -> opcode=5 (LDA), ir_addr=3. inc_pc at phase 4 -> pc 0 -> 1. Phase 7 -> 0 -> instr_count=1.
3. HLT: ld_ir with 8'h00, then at phase 4 halt=1 and inc_pc=1 -> halted=1, phase stays 4, pc increments once, then holds for 10 clocks. resume=1 -> phase=0, halted=0.
4. JMP: IR=8'hFD, ld_pc and inc_pc in the same cycle -> pc=29, not ir_addr+1. Separately, inc_pc from pc=31 -> pc=0.
5. addr mux: pc=9, ir_addr=20 -> addr=9 with sel=1 and addr=20 with sel=0, in the same cycle.
6. Single step (FETCH_SEQ_SINGLE_STEP_EN defined, step_mode=1): after phase 7 -> halted=1, phase=0, instr_count+1. Resume -> exactly one more 8-phase instruction, then halted again.
